// File: rtl/mctrl_pkg.sv
// Shared types for the multi-cycle sequencer: opcodes, ALUop codes, state and
// instruction-class enums, and the Moore control set decoded from (state, class).
package mctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_e;
  typedef enum logic [2:0] {R, LW, SW, BEQ, ADDI, ILL} class_e;

  typedef struct packed {
    logic       inst_ready;
    logic       reg_dst;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       pc_write;
    logic       illegal;
    logic       busy;
  } ctrl_t;

  // Controls that depend only on the state and latched class.
  function automatic ctrl_t moore_ctrl(input state_e st, input class_e cl);
    ctrl_t c;
    c = '0;
    case (st)
      FETCH: c.inst_ready = 1'b1;
      DECODE: begin
        c.busy    = 1'b1;
        c.illegal = (cl == ILL);
      end
      EXEC: begin
        c.busy = 1'b1;
        case (cl)
          R: begin
            c.alu_op  = ALU_FUNCT;
            c.reg_dst = 1'b1;
          end
          LW, SW, ADDI: begin
            c.alu_op  = ALU_ADD;
            c.alu_src = 1'b1;
          end
          BEQ: begin
            c.alu_op   = ALU_SUB;
            c.pc_write = 1'b1;
          end
          default: c.busy = 1'b1;
        endcase
      end
      MEM: begin
        c.busy      = 1'b1;
        c.alu_src   = 1'b1;
        c.mem_read  = (cl == LW);
        c.mem_write = (cl == SW);
      end
      WB: begin
        c.busy       = 1'b1;
        c.reg_write  = 1'b1;
        c.pc_write   = 1'b1;
        c.mem_to_reg = (cl == LW);
        c.reg_dst    = (cl == R);
        c.alu_op     = (cl == R) ? ALU_FUNCT : ALU_ADD;
      end
      default: c.inst_ready = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mctrl_decode.sv
// Combinational opcode to instruction-class mapping; anything unrecognised is ILL.
module mctrl_decode
  import mctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  output class_e     class_o
);

  always_comb begin
    class_o = ILL;
    case (opcode_i)
      OP_R:    class_o = R;
      OP_LW:   class_o = LW;
      OP_SW:   class_o = SW;
      OP_BEQ:  class_o = BEQ;
      OP_ADDI: class_o = ADDI;
      default: class_o = ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with a bounded MEM wait.
// Define MULTICYCLE_CTRL_PERF_EN to add retired_cnt/stall_cnt performance counters.
//
// Handshakes: fetch uses valid/ready -- an instruction transfers on a cycle where
// inst_valid and inst_ready are both high (ir_write marks that cycle); data memory
// completes on any MEM cycle where mem_ready is high, and mem_ready is ignored elsewhere.
module multicycle_ctrl
  import mctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       inst_valid,
  output logic       inst_ready,
  input  logic       is_zero,
  input  logic       mem_ready,
  output logic       RegDst,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemToReg,
  output logic       ALUSrc,
  output logic       RegWrite,
  output logic [1:0] ALUop,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       illegal,
  output logic       mem_err,
  output logic       busy
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || CNT_W < 1) begin : g_bad_param
    $error("multicycle_ctrl: MEM_TIMEOUT must be 1..255 and CNT_W at least 1");
  end

  state_e     state_q, state_d;
  class_e     class_q, class_d, dec_class;
  logic [7:0] wait_q, wait_d;
  ctrl_t      ctrl_q;
  logic       in_mem, sw_done, mem_abort;

  mctrl_decode u_decode (
    .opcode_i (opcode),
    .class_o  (dec_class)
  );

  assign in_mem    = (state_q == MEM);
  assign sw_done   = in_mem && (class_q == SW) && mem_ready;
  assign mem_abort = in_mem && !mem_ready && (wait_q == TIMEOUT);

  always_comb begin
    state_d = state_q;
    class_d = class_q;
    wait_d  = '0;
    case (state_q)
      FETCH: begin
        if (inst_valid) begin
          state_d = DECODE;
          class_d = dec_class;
        end
      end
      DECODE: state_d = (class_q == ILL) ? FETCH : EXEC;
      EXEC: begin
        case (class_q)
          R, ADDI: state_d = WB;
          LW, SW:  state_d = MEM;
          default: state_d = FETCH;
        endcase
      end
      MEM: begin
        // mem_ready on the timeout cycle still completes the access normally.
        if (mem_ready) begin
          state_d = (class_q == LW) ? WB : FETCH;
        end else if (wait_q == TIMEOUT) begin
          state_d = FETCH;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      WB:      state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Moore controls are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH;
      class_q <= ILL;
      wait_q  <= '0;
      ctrl_q  <= moore_ctrl(FETCH, ILL);
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      wait_q  <= wait_d;
      ctrl_q  <= moore_ctrl(state_d, class_d);
    end
  end

  assign inst_ready = ctrl_q.inst_ready;
  assign ir_write   = ctrl_q.inst_ready & inst_valid;
  assign RegDst     = ctrl_q.reg_dst;
  assign ALUop      = ctrl_q.alu_op;
  assign ALUSrc     = ctrl_q.alu_src;
  assign MemRead    = ctrl_q.mem_read;
  assign MemWrite   = ctrl_q.mem_write;
  assign MemToReg   = ctrl_q.mem_to_reg;
  assign RegWrite   = ctrl_q.reg_write;
  assign pc_write   = ctrl_q.pc_write | sw_done;
  assign pc_src     = (state_q == EXEC) && (class_q == BEQ) && is_zero;
  assign illegal    = ctrl_q.illegal;
  assign mem_err    = mem_abort;
  assign busy       = ctrl_q.busy;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [CNT_W-1:0] retired_q, stall_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      retired_q <= retired_q + CNT_W'(pc_write);
      stall_q   <= stall_q + CNT_W'(in_mem && !mem_ready);
    end
  end

  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected cycle sequences built from the
// instruction-class rules, checked every cycle, plus literal pulse-count checks.
module tb_multicycle_ctrl;

  localparam int W  = 15;
  localparam int TO = 15;

  localparam int B_IRDY = 14, B_IRW = 13, B_RDST = 12, B_ALU1 = 11, B_ALU0 = 10;
  localparam int B_ASRC = 9, B_MRD = 8, B_MWR = 7, B_M2R = 6, B_RW = 5;
  localparam int B_PCW = 4, B_PCSRC = 3, B_ILL = 2, B_MERR = 1, B_BUSY = 0;

  localparam logic [W-1:0] M_IRDY  = W'(1) << B_IRDY;
  localparam logic [W-1:0] M_IRW   = W'(1) << B_IRW;
  localparam logic [W-1:0] M_RDST  = W'(1) << B_RDST;
  localparam logic [W-1:0] M_ALU10 = W'(1) << B_ALU1;
  localparam logic [W-1:0] M_ALU01 = W'(1) << B_ALU0;
  localparam logic [W-1:0] M_ASRC  = W'(1) << B_ASRC;
  localparam logic [W-1:0] M_MRD   = W'(1) << B_MRD;
  localparam logic [W-1:0] M_MWR   = W'(1) << B_MWR;
  localparam logic [W-1:0] M_M2R   = W'(1) << B_M2R;
  localparam logic [W-1:0] M_RW    = W'(1) << B_RW;
  localparam logic [W-1:0] M_PCW   = W'(1) << B_PCW;
  localparam logic [W-1:0] M_PCSRC = W'(1) << B_PCSRC;
  localparam logic [W-1:0] M_ILL   = W'(1) << B_ILL;
  localparam logic [W-1:0] M_MERR  = W'(1) << B_MERR;
  localparam logic [W-1:0] M_BUSY  = W'(1) << B_BUSY;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_BAD = 6'b111111;
  localparam int C_R = 0, C_LW = 1, C_SW = 2, C_BEQ = 3, C_ADDI = 4, C_ILL = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       inst_valid, is_zero, mem_ready;
  logic       inst_ready, RegDst, MemRead, MemWrite, MemToReg, ALUSrc, RegWrite;
  logic [1:0] ALUop;
  logic       ir_write, pc_write, pc_src, illegal, mem_err, busy;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] retired_cnt, stall_cnt;
  logic [31:0] m_ret = '0, m_stall = '0;
  logic [31:0] exp_ret_q[$], exp_stall_q[$];
  logic [31:0] s_stall;
`endif

  logic [W-1:0] exp_q[$];
  logic [W-1:0] dut_vec, cmp_e;
  string        lit_name_q[$];
  int           lit_got_q[$], lit_exp_q[$];
  int           checks = 0, errors = 0;
  int mon_pcw = 0, mon_busy = 0, mon_mrd = 0, mon_mwr = 0, mon_merr = 0;
  int mon_ill = 0, mon_rw = 0, mon_m2r = 0, mon_pcsrc = 0;
  int s_pcw, s_busy, s_mrd, s_mwr, s_merr, s_ill, s_rw, s_m2r, s_pcsrc;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .is_zero    (is_zero),
    .mem_ready  (mem_ready),
    .RegDst     (RegDst),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemToReg   (MemToReg),
    .ALUSrc     (ALUSrc),
    .RegWrite   (RegWrite),
    .ALUop      (ALUop),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .illegal    (illegal),
    .mem_err    (mem_err),
    .busy       (busy)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .retired_cnt (retired_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  assign dut_vec = {inst_ready, ir_write, RegDst, ALUop, ALUSrc, MemRead, MemWrite,
                    MemToReg, RegWrite, pc_write, pc_src, illegal, mem_err, busy};

  // Single compare process: cycle vectors, counters, and queued literal checks.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cmp_e = exp_q.pop_front();
      checks++;
      if (dut_vec !== cmp_e) begin
        errors++;
        $display("FAIL ctrl_vec t=%0t got=%b exp=%b", $time, dut_vec, cmp_e);
      end
`ifdef MULTICYCLE_CTRL_PERF_EN
      begin
        logic [31:0] er, es;
        er = exp_ret_q.pop_front();
        es = exp_stall_q.pop_front();
        checks++;
        if (retired_cnt !== er || stall_cnt !== es) begin
          errors++;
          $display("FAIL perf_cnt t=%0t got ret=%0d stall=%0d exp ret=%0d stall=%0d",
                   $time, retired_cnt, stall_cnt, er, es);
        end
      end
`endif
    end
    mon_pcw   += int'(pc_write);
    mon_busy  += int'(busy);
    mon_mrd   += int'(MemRead);
    mon_mwr   += int'(MemWrite);
    mon_merr  += int'(mem_err);
    mon_ill   += int'(illegal);
    mon_rw    += int'(RegWrite);
    mon_m2r   += int'(MemToReg);
    mon_pcsrc += int'(pc_src);
    while (lit_got_q.size() > 0) begin
      string n;
      int g, x;
      n = lit_name_q.pop_front();
      g = lit_got_q.pop_front();
      x = lit_exp_q.pop_front();
      checks++;
      if (g != x) begin
        errors++;
        $display("FAIL %s got=%0d exp=%0d", n, g, x);
      end
    end
  end

  function automatic int op_class(input logic [5:0] op);
    case (op)
      OP_R:    return C_R;
      OP_LW:   return C_LW;
      OP_SW:   return C_SW;
      OP_BEQ:  return C_BEQ;
      OP_ADDI: return C_ADDI;
      default: return C_ILL;
    endcase
  endfunction

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] rnd6();
    return 6'($urandom_range(0, 63));
  endfunction

  task automatic lit(input string n, input int got, input int exp);
    lit_name_q.push_back(n);
    lit_got_q.push_back(got);
    lit_exp_q.push_back(exp);
  endtask

  // One clock cycle: drive inputs just after the edge and record what that cycle must show.
  task automatic cyc(input logic [W-1:0] e, input logic iv, input logic [5:0] op,
                     input logic mr, input logic z, input logic rst, input logic stall);
    @(posedge clk);
    #1;
    inst_valid = iv;
    opcode     = op;
    mem_ready  = mr;
    is_zero    = z;
    reset      = rst;
    exp_q.push_back(e);
`ifdef MULTICYCLE_CTRL_PERF_EN
    exp_ret_q.push_back(m_ret);
    exp_stall_q.push_back(m_stall);
    if (!rst) begin
      m_ret   = '0;
      m_stall = '0;
    end else begin
      m_ret   = m_ret + 32'(e[B_PCW]);
      m_stall = m_stall + 32'(stall);
    end
`else
    if (stall === 1'bx) $display("stall flag undefined");
`endif
  endtask

  task automatic idle();
    cyc(M_IRDY, 1'b0, rnd6(), rnd1(), rnd1(), 1'b1, 1'b0);
  endtask

  // waits: MEM cycles before mem_ready (above TO means never); rst_at: MEM cycle to reset in.
  task automatic do_instr(input logic [5:0] op, input int waits, input logic z, input int rst_at);
    int cl;
    logic [W-1:0] e;
    logic mr;
    cl = op_class(op);
    cyc(M_IRDY | M_IRW, 1'b1, op, rnd1(), rnd1(), 1'b1, 1'b0);
    e = M_BUSY | ((cl == C_ILL) ? M_ILL : '0);
    cyc(e, rnd1(), rnd6(), rnd1(), rnd1(), 1'b1, 1'b0);
    if (cl == C_ILL) return;
    e = M_BUSY;
    if (cl == C_R) e |= M_ALU10 | M_RDST;
    else if (cl == C_BEQ) e |= M_ALU01 | M_PCW | (z ? M_PCSRC : '0);
    else e |= M_ASRC;
    cyc(e, rnd1(), rnd6(), rnd1(), (cl == C_BEQ) ? z : rnd1(), 1'b1, 1'b0);
    if (cl == C_BEQ) return;
    if (cl == C_LW || cl == C_SW) begin
      for (int k = 0; k <= TO; k++) begin
        e = M_BUSY | M_ASRC | ((cl == C_LW) ? M_MRD : M_MWR);
        if (k == rst_at) begin
          cyc(e, rnd1(), rnd6(), 1'b0, rnd1(), 1'b0, 1'b1);
          return;
        end
        mr = (k == waits);
        if (mr && cl == C_SW) e |= M_PCW;
        if (!mr && k == TO) e |= M_MERR;
        cyc(e, rnd1(), rnd6(), mr, rnd1(), 1'b1, !mr);
        if (mr && cl == C_SW) return;
        if (mr) break;
        if (k == TO) return;
      end
    end
    e = M_BUSY | M_RW | M_PCW;
    if (cl == C_R) e |= M_ALU10 | M_RDST;
    if (cl == C_LW) e |= M_M2R;
    cyc(e, rnd1(), rnd6(), rnd1(), rnd1(), 1'b1, 1'b0);
  endtask

  task automatic snap();
    s_pcw = mon_pcw; s_busy = mon_busy; s_mrd = mon_mrd; s_mwr = mon_mwr;
    s_merr = mon_merr; s_ill = mon_ill; s_rw = mon_rw; s_m2r = mon_m2r;
    s_pcsrc = mon_pcsrc;
  endtask

  initial begin
    reset = 1'b0; inst_valid = 1'b0; opcode = '0; mem_ready = 1'b0; is_zero = 1'b0;
    for (int i = 0; i < 3; i++) cyc(M_IRDY, 1'b0, rnd6(), rnd1(), rnd1(), 1'b0, 1'b0);
    idle();

    snap();
    do_instr(OP_R, 0, 1'b0, -1);
    idle();
    lit("r_busy_cycles", mon_busy - s_busy, 3);
    lit("r_pc_write", mon_pcw - s_pcw, 1);
    lit("r_reg_write", mon_rw - s_rw, 1);
`ifdef MULTICYCLE_CTRL_PERF_EN
    lit("retired_first", int'(retired_cnt), 1);
`endif

    snap();
    do_instr(OP_BEQ, 0, 1'b1, -1);
    do_instr(OP_BEQ, 0, 1'b0, -1);
    idle();
    lit("beq_pc_src", mon_pcsrc - s_pcsrc, 1);
    lit("beq_pc_write", mon_pcw - s_pcw, 2);
    lit("beq_no_regwr", (mon_rw - s_rw) + (mon_mwr - s_mwr), 0);

    snap();
`ifdef MULTICYCLE_CTRL_PERF_EN
    s_stall = stall_cnt;
`endif
    do_instr(OP_LW, 3, 1'b0, -1);
    idle();
    lit("lw_mem_read", mon_mrd - s_mrd, 4);
    lit("lw_mem_to_reg", mon_m2r - s_m2r, 1);
    lit("lw_busy_cycles", mon_busy - s_busy, 7);
`ifdef MULTICYCLE_CTRL_PERF_EN
    lit("lw_stall_cnt", int'(stall_cnt - s_stall), 3);
`endif

    snap();
    do_instr(OP_SW, 100, 1'b0, -1);
    idle();
    lit("sw_to_mem_write", mon_mwr - s_mwr, 16);
    lit("sw_to_mem_err", mon_merr - s_merr, 1);
    lit("sw_to_pc_write", mon_pcw - s_pcw, 0);

    snap();
    do_instr(OP_SW, TO, 1'b0, -1);
    idle();
    lit("sw_edge_mem_err", mon_merr - s_merr, 0);
    lit("sw_edge_pc_write", mon_pcw - s_pcw, 1);

    snap();
    do_instr(OP_BAD, 0, 1'b0, -1);
    idle();
    lit("ill_pulse", mon_ill - s_ill, 1);
    lit("ill_pc_write", mon_pcw - s_pcw, 0);
    lit("ill_busy", mon_busy - s_busy, 1);

    snap();
    do_instr(OP_LW, 10, 1'b0, 2);
    do_instr(OP_ADDI, 0, 1'b0, -1);
    idle();
    lit("rst_lw_mem_read", mon_mrd - s_mrd, 3);
    lit("rst_addi_pc_write", mon_pcw - s_pcw, 1);
    lit("rst_addi_reg_write", mon_rw - s_rw, 1);

    for (int n = 0; n < 200; n++) begin
      logic [5:0] op;
      int sel, w, ra;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    op = OP_R;
        2, 3:    op = OP_LW;
        4, 5:    op = OP_SW;
        6:       op = OP_BEQ;
        7:       op = OP_ADDI;
        default: op = rnd6();
      endcase
      w  = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 2) : $urandom_range(0, 3);
      ra = ($urandom_range(0, 24) == 0) ? $urandom_range(0, 2) : -1;
      do_instr(op, w, rnd1(), ra);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
